// File: rtl/dp_seq_pkg.sv
// Shared types for the datapath test sequencer: FSM states and load-stream word kinds.
package dp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    LD_IMEM = 2'd0,
    LD_REG  = 2'd1,
    LD_EXP  = 2'd2,
    LD_END  = 2'd3
  } ld_kind_t;

  // A scanned entry fails only when an expectation was loaded for it.
  function automatic logic entry_mismatch(input logic valid, input logic differs);
    return valid & differs;
  endfunction

endpackage

// File: rtl/dp_seq_expect_store.sv
// Expected register values plus per-entry valid flags; written from the load
// stream, read asynchronously at the register-file scan address.
module dp_seq_expect_store
  import dp_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam logic [REG_AW:0] NUM_REGS_C = (REG_AW+1)'(NUM_REGS);

  logic [DATA_W-1:0]   exp_r [NUM_REGS];
  logic [NUM_REGS-1:0] exp_valid_r;
  logic                waddr_ok_s;
  logic                raddr_ok_s;

  assign waddr_ok_s = ({1'b0, waddr} < NUM_REGS_C);
  assign raddr_ok_s = ({1'b0, raddr} < NUM_REGS_C);

  // Valid flags: cleared on reset and at the start of every load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid_r <= '0;
    end else if (clr) begin
      exp_valid_r <= '0;
    end else if (we && waddr_ok_s) begin
      exp_valid_r[waddr] <= 1'b1;
    end
  end

  // Expected data array; only meaningful where the valid flag is set.
  always_ff @(posedge clk) begin
    if (we && waddr_ok_s) begin
      exp_r[waddr] <= wdata;
    end
  end

  // Asynchronous read port.
  always_comb begin
    rdata  = '0;
    rvalid = 1'b0;
    if (raddr_ok_s) begin
      rdata  = exp_r[raddr];
      rvalid = exp_valid_r[raddr];
    end else begin
      rdata  = '0;
      rvalid = 1'b0;
    end
  end

endmodule

// File: rtl/dp_test_sequencer.sv
// Datapath test sequencer: load program/preloads, run N CPU cycles, scan registers.
// Optional mismatch log ports are enabled by defining DP_SEQ_MISMATCH_LOG_EN.
module dp_test_sequencer
  import dp_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int IMEM_AW  = 6,
  parameter int CYC_W    = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CYC_W-1:0]   run_cycles,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [1:0]         ld_kind,
  input  logic [IMEM_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  output logic               dut_reset,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               rf_we,
  output logic [REG_AW-1:0]  rf_addr,
  output logic [DATA_W-1:0]  rf_wdata,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [REG_AW:0]    fail_count,
  output logic [REG_AW-1:0]  first_fail
`ifdef DP_SEQ_MISMATCH_LOG_EN
  ,
  output logic               mm_valid,
  output logic [REG_AW-1:0]  mm_reg,
  output logic [DATA_W-1:0]  mm_got,
  output logic [DATA_W-1:0]  mm_exp
`endif
);

  localparam logic [REG_AW:0]   NUM_REGS_C = (REG_AW+1)'(NUM_REGS);
  localparam logic [REG_AW:0]   FC_ONE_C   = (REG_AW+1)'(32'd1);
  localparam logic [REG_AW-1:0] LAST_IDX_C = REG_AW'(NUM_REGS - 1);
  localparam logic [REG_AW-1:0] IDX_ONE_C  = REG_AW'(32'd1);
  localparam logic [CYC_W-1:0]  CYC_ONE_C  = CYC_W'(32'd1);

  seq_state_t         state_r;
  logic [CYC_W-1:0]   cyc_cnt_r;
  logic [REG_AW-1:0]  chk_idx_r;
  logic               ld_ready_r;
  logic               dut_reset_r;
  logic               busy_r;
  logic               done_r;
  logic               pass_r;
  logic [REG_AW:0]    fail_count_r;
  logic [REG_AW-1:0]  first_fail_r;

  ld_kind_t           kind_s;
  logic               hs_s;
  logic               imem_we_s;
  logic               rf_we_s;
  logic               exp_we_s;
  logic               exp_clr_s;
  logic [DATA_W-1:0]  exp_rdata_s;
  logic               exp_rvalid_s;
  logic               mismatch_s;
  logic [IMEM_AW-1:0] imem_addr_s;
  logic [DATA_W-1:0]  imem_wdata_s;
  logic [REG_AW-1:0]  rf_addr_s;
  logic [DATA_W-1:0]  rf_wdata_s;

  assign kind_s     = ld_kind_t'(ld_kind);
  assign hs_s       = ld_ready_r & ld_valid;
  assign imem_we_s  = hs_s & (kind_s == LD_IMEM);
  assign rf_we_s    = hs_s & (kind_s == LD_REG);
  assign exp_we_s   = hs_s & (kind_s == LD_EXP);
  assign exp_clr_s  = start & ((state_r == IDLE) | (state_r == DONE));
  assign mismatch_s = (state_r == CHECK) &
                      entry_mismatch(exp_rvalid_s, rf_rdata != exp_rdata_s);

  dp_seq_expect_store #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_expect_store (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (exp_clr_s),
    .we     (exp_we_s),
    .waddr  (ld_addr[REG_AW-1:0]),
    .wdata  (ld_data),
    .raddr  (rf_addr_s),
    .rdata  (exp_rdata_s),
    .rvalid (exp_rvalid_s)
  );

  // Backdoor ports: stream passes straight through while loading, scan index while checking.
  always_comb begin
    imem_addr_s  = '0;
    imem_wdata_s = '0;
    rf_addr_s    = '0;
    rf_wdata_s   = '0;
    if (imem_we_s) begin
      imem_addr_s  = ld_addr;
      imem_wdata_s = ld_data;
    end else begin
      imem_addr_s  = '0;
      imem_wdata_s = '0;
    end
    if (state_r == CHECK) begin
      rf_addr_s  = chk_idx_r;
      rf_wdata_s = '0;
    end else if (rf_we_s) begin
      rf_addr_s  = ld_addr[REG_AW-1:0];
      rf_wdata_s = ld_data;
    end else begin
      rf_addr_s  = '0;
      rf_wdata_s = '0;
    end
  end

  // Sequencer FSM with its registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cyc_cnt_r    <= '0;
      chk_idx_r    <= '0;
      ld_ready_r   <= 1'b0;
      dut_reset_r  <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_count_r <= '0;
      first_fail_r <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r      <= LOAD;
            ld_ready_r   <= 1'b1;
            dut_reset_r  <= 1'b1;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_count_r <= '0;
            first_fail_r <= '0;
          end
        end
        LOAD: begin
          if (hs_s && (kind_s == LD_END)) begin
            cyc_cnt_r  <= run_cycles;
            chk_idx_r  <= '0;
            ld_ready_r <= 1'b0;
            // A zero-length run skips RUN so the CPU never leaves reset.
            if (run_cycles == '0) begin
              state_r     <= CHECK;
              dut_reset_r <= 1'b1;
            end else begin
              state_r     <= RUN;
              dut_reset_r <= 1'b0;
            end
          end
        end
        RUN: begin
          if (cyc_cnt_r == CYC_ONE_C) begin
            state_r     <= CHECK;
            dut_reset_r <= 1'b1;
            chk_idx_r   <= '0;
          end else begin
            cyc_cnt_r <= cyc_cnt_r - CYC_ONE_C;
          end
        end
        CHECK: begin
          if (mismatch_s) begin
            if (fail_count_r == '0) begin
              first_fail_r <= chk_idx_r;
            end
            if (fail_count_r < NUM_REGS_C) begin
              fail_count_r <= fail_count_r + FC_ONE_C;
            end
          end
          if (chk_idx_r == LAST_IDX_C) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (fail_count_r == '0) & ~mismatch_s;
          end else begin
            chk_idx_r <= chk_idx_r + IDX_ONE_C;
          end
        end
        default: begin
          state_r     <= IDLE;
          ld_ready_r  <= 1'b0;
          dut_reset_r <= 1'b1;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          pass_r      <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready   = ld_ready_r;
  assign dut_reset  = dut_reset_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign fail_count = fail_count_r;
  assign first_fail = first_fail_r;
  assign imem_we    = imem_we_s;
  assign imem_addr  = imem_addr_s;
  assign imem_wdata = imem_wdata_s;
  assign rf_we      = rf_we_s;
  assign rf_addr    = rf_addr_s;
  assign rf_wdata   = rf_wdata_s;

`ifdef DP_SEQ_MISMATCH_LOG_EN
  logic              mm_valid_r;
  logic [REG_AW-1:0] mm_reg_r;
  logic [DATA_W-1:0] mm_got_r;
  logic [DATA_W-1:0] mm_exp_r;

  // One-cycle log pulse per mismatch, one cycle after the compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_valid_r <= 1'b0;
      mm_reg_r   <= '0;
      mm_got_r   <= '0;
      mm_exp_r   <= '0;
    end else begin
      mm_valid_r <= mismatch_s;
      if (mismatch_s) begin
        mm_reg_r <= chk_idx_r;
        mm_got_r <= rf_rdata;
        mm_exp_r <= exp_rdata_s;
      end
    end
  end

  assign mm_valid = mm_valid_r;
  assign mm_reg   = mm_reg_r;
  assign mm_got   = mm_got_r;
  assign mm_exp   = mm_exp_r;
`endif

endmodule
